mem_access_ctrl: RTL and testbench

Sequences multi-cycle data-memory accesses for the MEM stage and produces the pipeline stall.
- Inputs: MemRead/MemWrite/ALU address/store data, as presented by the EX/MEM pipeline register.
- Issues a req/ack transaction to the data memory.
- Holds stall_o high so the pipeline registers freeze until the access completes.
- Returns load data to the MEM/WB path.

---
 rtl/mem_access_ctrl_pkg.sv | 18 +
 rtl/mem_perf_cnt.sv | 21 ++
 rtl/mem_access_ctrl.sv | 114 +++++++++++
 tb/tb_mem_access_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared state encoding and width defaults for the MEM-stage access controller
package mem_access_ctrl_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } mac_state_e;

   // A load and a store presented together resolve to a store.
   function automatic logic access_is_write(input logic mem_read, input logic mem_write);
      return mem_write | (mem_read & mem_write);
   endfunction

endpackage

// File: rtl/mem_perf_cnt.sv
// rtl/mem_perf_cnt.sv - free-running stall-cycle and completed-transfer counters
module mem_perf_cnt (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall,
   input  logic        xfer,
   output logic [31:0] stall_cnt,
   output logic [31:0] access_cnt
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt  <= 32'd0;
         access_cnt <= 32'd0;
      end else begin
         if (stall) stall_cnt <= stall_cnt + 32'd1;
         if (xfer)  access_cnt <= access_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage req/ack access sequencer and pipeline stall; MEM_STALL_CNT_EN adds perf counters
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [ADDR_W-1:0] Addr_i,
   input  logic [DATA_W-1:0] WrData_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] RdData_o,
   output logic              RdValid_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
`ifdef MEM_STALL_CNT_EN
   output logic [31:0]       StallCnt_o,
   output logic [31:0]       AccessCnt_o,
`endif
   input  logic [DATA_W-1:0] mem_rdata_i
);

   mac_state_e        state_q, state_d;
   logic              req_d, we_d, rd_valid_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d, rd_data_d;
   logic              access_req;
   logic              xfer;

   assign access_req = MemRead_i | MemWrite_i;
   assign xfer       = (state_q == ST_WAIT) & mem_req_o & mem_ack_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         RdData_o    <= '0;
         RdValid_o   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_o   <= req_d;
         mem_we_o    <= we_d;
         mem_addr_o  <= addr_d;
         mem_wdata_o <= wdata_d;
         RdData_o    <= rd_data_d;
         RdValid_o   <= rd_valid_d;
      end
   end

   // stall_o drops in DONE so the EX/MEM register advances and the access is not re-issued.
   always_comb begin
      state_d    = state_q;
      req_d      = mem_req_o;
      we_d       = mem_we_o;
      addr_d     = mem_addr_o;
      wdata_d    = mem_wdata_o;
      rd_data_d  = RdData_o;
      rd_valid_d = RdValid_o;
      stall_o    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access_req) begin
               stall_o = 1'b1;
               req_d   = 1'b1;
               we_d    = access_is_write(MemRead_i, MemWrite_i);
               addr_d  = Addr_i;
               wdata_d = WrData_i;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            stall_o = 1'b1;
            if (xfer) begin
               req_d   = 1'b0;
               state_d = ST_DONE;
               if (!mem_we_o) begin
                  rd_data_d  = mem_rdata_i;
                  rd_valid_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            rd_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
         default: begin
            req_d      = 1'b0;
            rd_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

`ifdef MEM_STALL_CNT_EN
   mem_perf_cnt u_perf_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .stall      (stall_o),
      .xfer       (xfer),
      .stall_cnt  (StallCnt_o),
      .access_cnt (AccessCnt_o)
   );
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - table-driven scoreboard bench for mem_access_ctrl (optionally with MEM_STALL_CNT_EN)
module tb_mem_access_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        MemRead_i, MemWrite_i;
   logic [31:0] Addr_i, WrData_i;
   logic        stall_o;
   logic [31:0] RdData_o;
   logic        RdValid_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
`ifdef MEM_STALL_CNT_EN
   logic [31:0] StallCnt_o, AccessCnt_o;
`endif

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .MemRead_i   (MemRead_i),
      .MemWrite_i  (MemWrite_i),
      .Addr_i      (Addr_i),
      .WrData_i    (WrData_i),
      .stall_o     (stall_o),
      .RdData_o    (RdData_o),
      .RdValid_o   (RdValid_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
`ifdef MEM_STALL_CNT_EN
      .StallCnt_o  (StallCnt_o),
      .AccessCnt_o (AccessCnt_o),
`endif
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_dly;
      logic        exp_we;
      logic        exp_rdv;
      logic [31:0] exp_rdd;
   } vec_t;

   typedef struct {
      logic        rdv;
      logic [31:0] rdd;
      int          stall_cycles;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},    mem_req_o,   0);
      chk({tag, "_we"},     mem_we_o,    0);
      chk({tag, "_addr"},   mem_addr_o,  0);
      chk({tag, "_wdata"},  mem_wdata_o, 0);
      chk({tag, "_rddata"}, RdData_o,    0);
      chk({tag, "_rdv"},    RdValid_o,   0);
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   stalls;
      @(negedge clk_i);
      MemRead_i  = v.rd;
      MemWrite_i = v.wr;
      Addr_i     = v.addr;
      WrData_i   = v.wdata;
      e.rdv = v.exp_rdv;
      e.rdd = v.exp_rdd;
      e.stall_cycles = v.ack_dly + 2;
      sb.push_back(e);
      #1;
      chk("idle_stall", stall_o, 1);
      chk("idle_req", mem_req_o, 0);
      chk("idle_rdv", RdValid_o, 0);
      stalls = int'(stall_o);
      for (int k = 0; k <= v.ack_dly; k++) begin
         @(negedge clk_i);
         chk("wait_req",   mem_req_o,   1);
         chk("wait_we",    mem_we_o,    v.exp_we);
         chk("wait_addr",  mem_addr_o,  v.addr);
         chk("wait_wdata", mem_wdata_o, v.wdata);
         chk("wait_rdv",   RdValid_o,   0);
         stalls += int'(stall_o);
         if (k >= 1) begin
            MemRead_i  = ~v.rd;
            MemWrite_i = ~v.wr;
            Addr_i     = ~v.addr;
         end
         mem_ack_i   = (k == v.ack_dly);
         mem_rdata_i = (k == v.ack_dly) ? v.rdata : ~v.rdata;
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      chk("done_stall", stall_o, 0);
      chk("done_req", mem_req_o, 0);
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("done_rdv", RdValid_o, e.rdv);
         chk("done_rddata", RdData_o, e.rdd);
         chk("stall_cycles", stalls, e.stall_cycles);
      end
      MemRead_i  = 1'b0;
      MemWrite_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{rd:1, wr:0, addr:32'h40,  wdata:32'h0,        rdata:32'hDEADBEEF, ack_dly:0, exp_we:0, exp_rdv:1, exp_rdd:32'hDEADBEEF};
      vecs[1] = '{rd:0, wr:1, addr:32'h80,  wdata:32'h12345678, rdata:32'h99999999, ack_dly:3, exp_we:1, exp_rdv:0, exp_rdd:32'hDEADBEEF};
      vecs[2] = '{rd:1, wr:0, addr:32'h100, wdata:32'h0,        rdata:32'hCAFEF00D, ack_dly:0, exp_we:0, exp_rdv:1, exp_rdd:32'hCAFEF00D};
      vecs[3] = '{rd:0, wr:1, addr:32'h104, wdata:32'hA5A5A5A5, rdata:32'h77777777, ack_dly:0, exp_we:1, exp_rdv:0, exp_rdd:32'hCAFEF00D};
      vecs[4] = '{rd:1, wr:1, addr:32'h200, wdata:32'h11112222, rdata:32'h55555555, ack_dly:1, exp_we:1, exp_rdv:0, exp_rdd:32'hCAFEF00D};
      vecs[5] = '{rd:1, wr:0, addr:32'h204, wdata:32'h0,        rdata:32'h0BADF00D, ack_dly:2, exp_we:0, exp_rdv:1, exp_rdd:32'h0BADF00D};

      rst_i       = 1'b1;
      MemRead_i   = 1'b0;
      MemWrite_i  = 1'b0;
      Addr_i      = '0;
      WrData_i    = '0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      #1;
      chk_all_zero("reset");
      chk("reset_stall", stall_o, 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
`ifdef MEM_STALL_CNT_EN
         if (i == 1) begin
            chk("stall_cnt", StallCnt_o, 7);
            chk("access_cnt", AccessCnt_o, 2);
         end
`endif
      end

      // Spurious ack with no outstanding request
      @(negedge clk_i);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hFFFF0000;
      #1;
      chk("spur_stall", stall_o, 0);
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      chk("spur_req", mem_req_o, 0);
      chk("spur_rdv", RdValid_o, 0);
      chk("spur_rddata", RdData_o, 32'h0BADF00D);
      @(negedge clk_i);
      chk("spur_req2", mem_req_o, 0);

      // Reset while WAIT holds an outstanding request
      MemRead_i = 1'b1;
      Addr_i    = 32'h300;
      @(negedge clk_i);
      chk("rst_wait_req", mem_req_o, 1);
      chk("rst_wait_stall", stall_o, 1);
      MemRead_i = 1'b0;
      rst_i     = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      chk("rst_mid_stall", stall_o, 0);
`ifdef MEM_STALL_CNT_EN
      chk("rst_stall_cnt", StallCnt_o, 0);
      chk("rst_access_cnt", AccessCnt_o, 0);
`endif
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("post_rst_stall", stall_o, 0);
      chk("post_rst_req", mem_req_o, 0);

      // Normal access after reset release
      run_vec('{rd:1, wr:0, addr:32'h44, wdata:32'h0, rdata:32'h13572468, ack_dly:1,
                exp_we:0, exp_rdv:1, exp_rdd:32'h13572468});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
